mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: address width of all ports.
REQ-002 Parameter DATA_W, default 32: data width of all ports.
REQ-003 Parameter MAX_D_RUN, default 4: max consecutive data grants while a fetch is pending.
REQ-004 i_clk  in  1  single clock; all state changes on rising edge.
REQ-005 i_rstn  in  1  reset, asynchronous assert, active-low.
REQ-006 i_if_req  in  1  fetch request, held until o_if_ack; i_if_addr  in  ADDR_W  fetch address.
REQ-007 o_if_rdata  out  DATA_W  fetch data, valid while o_if_ack=1; o_if_ack  out  1  one-cycle completion pulse.
REQ-008 i_d_req  in  1  data request, held until o_d_ack; i_d_we  in  1  1=store; i_d_be  in  DATA_W/8  byte enables; i_d_addr  in  ADDR_W; i_d_wdata  in  DATA_W.
REQ-009 o_d_rdata  out  DATA_W  load data, valid while o_d_ack=1; o_d_ack  out  1  one-cycle completion pulse.
REQ-010 o_mem_req  out  1; o_mem_we  out  1; o_mem_be  out  DATA_W/8; o_mem_addr  out  ADDR_W; o_mem_wdata  out  DATA_W: single shared memory port.
REQ-011 i_mem_rdata  in  DATA_W; i_mem_ack  in  1  memory completion, any latency >=0 cycles after o_mem_req rises.
REQ-012 o_busy  out  1  high in every state except IDLE.

Function
REQ-013 FSM states IDLE, IF_BUSY, D_BUSY, RESP; reset state IDLE.
REQ-014 IDLE, no request: stay IDLE, o_mem_req=0.
REQ-015 IDLE, request(s) present: grant per REQ-020, latch winner's addr/we/be/wdata into registers, go IF_BUSY or D_BUSY.
REQ-016 IF_BUSY/D_BUSY: o_mem_req=1, o_mem_* driven only from latched registers; hold until i_mem_ack=1.
REQ-017 i_mem_ack=1 in BUSY state: register i_mem_rdata into winner's rdata register, go RESP.
REQ-018 RESP: pulse winner's ack for exactly one cycle, other ack 0, o_mem_req=0, requests ignored; go IDLE.
REQ-019 Latency: request sampled in IDLE at edge k -> o_mem_req high cycle k+1; with i_mem_ack in that cycle, ack high cycle k+2; back-to-back issue every 3 cycles minimum.
REQ-020 Priority: data wins over fetch, except when starvation counter = MAX_D_RUN and i_if_req=1, then fetch wins.
REQ-021 Starvation counter: +1 on data grant while i_if_req=1, saturating at MAX_D_RUN; cleared on fetch grant or on data grant with i_if_req=0.
REQ-022 Fetch requests never write: o_mem_we=0, o_mem_be all ones, o_mem_wdata=0 during IF_BUSY.
REQ-023 i_mem_ack while IDLE or RESP ignored; request-input changes during BUSY have no effect on o_mem_*.
REQ-024 Store completion also pulses o_d_ack; o_d_rdata then holds the captured i_mem_rdata value (don't-care to requester).

Reset
REQ-025 i_rstn=0 asynchronously forces state IDLE, counter 0, all outputs 0, latched registers 0.
REQ-026 Reset mid-transfer abandons the transfer; no ack issued after reset release; first decision at first edge with i_rstn=1.

Structure
REQ-027 State encoding (2-bit) and default width constants live in the shared project package/include; no local redefinition.
REQ-028 Single flat module; no sub-module; counter width = $clog2(MAX_D_RUN+1).

Verification
REQ-029 Fetch only: i_if_addr=0x100, mem ack 0-wait, rdata 0x00000013 -> o_mem_addr=0x100 cycle k+1, o_if_ack=1 with o_if_rdata=0x00000013 cycle k+2.
REQ-030 Simultaneous i_if_req and i_d_req (load 0x2000) -> data served first, fetch served next, each ack single-cycle, order D then IF.
REQ-031 Continuous i_d_req plus pending i_if_req, MAX_D_RUN=4 -> grant pattern D,D,D,D,IF repeating; fetch never waits more than 4 data transfers.
REQ-032 Store 0xDEADBEEF, be=4'b0011, addr 0x3004, mem ack after 3 wait cycles -> o_mem_we=1, be/addr/wdata stable all 4 BUSY cycles, o_d_ack once.
REQ-033 i_rstn low during D_BUSY with mem not acking -> all outputs 0 immediately; after release, no stray o_d_ack; new fetch completes normally.
REQ-034 i_mem_ack pulsed while IDLE -> no ack output, state remains IDLE, o_busy=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM state encoding and
// default port widths used as parameter defaults by the top module.
package mem_arbiter_pkg;

    localparam int DEF_ADDR_W    = 32;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_MAX_D_RUN = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_IF_BUSY = 2'd1,
        ST_D_BUSY  = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (instruction fetch / data) arbiter in front of a single
// memory port. Data normally wins; a saturating run counter lets a pending
// fetch through after MAX_D_RUN consecutive data grants. Each transfer goes
// IDLE -> BUSY -> RESP, so one transfer completes every 3 cycles at best.
// MAX_D_RUN must be at least 1.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int MAX_D_RUN = DEF_MAX_D_RUN
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic [DATA_W-1:0]   o_if_rdata,
    output logic                o_if_ack,
    input  logic                i_d_req,
    input  logic                i_d_we,
    input  logic [DATA_W/8-1:0] i_d_be,
    input  logic [ADDR_W-1:0]   i_d_addr,
    input  logic [DATA_W-1:0]   i_d_wdata,
    output logic [DATA_W-1:0]   o_d_rdata,
    output logic                o_d_ack,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [DATA_W/8-1:0] o_mem_be,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    input  logic                i_mem_ack,
    output logic                o_busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_D_RUN + 1);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(MAX_D_RUN);

    arb_state_e        state_reg, state_next;
    logic [CNT_W-1:0]  run_reg, run_next;
    logic              win_d_reg, win_d_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              we_reg, we_next;
    logic [BE_W-1:0]   be_reg, be_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [DATA_W-1:0] if_rdata_reg, if_rdata_next;
    logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;
    logic              grant_d;
    logic              mem_phase;

    // State and latched-request registers; reset abandons any transfer.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg    <= ST_IDLE;
            run_reg      <= '0;
            win_d_reg    <= 1'b0;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            be_reg       <= '0;
            wdata_reg    <= '0;
            if_rdata_reg <= '0;
            d_rdata_reg  <= '0;
        end else begin
            state_reg    <= state_next;
            run_reg      <= run_next;
            win_d_reg    <= win_d_next;
            addr_reg     <= addr_next;
            we_reg       <= we_next;
            be_reg       <= be_next;
            wdata_reg    <= wdata_next;
            if_rdata_reg <= if_rdata_next;
            d_rdata_reg  <= d_rdata_next;
        end
    end

    // Arbitration, request latching and transfer sequencing.
    always_comb begin
        state_next    = state_reg;
        run_next      = run_reg;
        win_d_next    = win_d_reg;
        addr_next     = addr_reg;
        we_next       = we_reg;
        be_next       = be_reg;
        wdata_next    = wdata_reg;
        if_rdata_next = if_rdata_reg;
        d_rdata_next  = d_rdata_reg;
        // Data wins unless the fetch has already waited out a full run.
        grant_d       = i_d_req && !(i_if_req && (run_reg == RUN_MAX));

        case (state_reg)
            ST_IDLE: begin
                if (grant_d) begin
                    win_d_next = 1'b1;
                    addr_next  = i_d_addr;
                    we_next    = i_d_we;
                    be_next    = i_d_be;
                    wdata_next = i_d_wdata;
                    state_next = ST_D_BUSY;
                    // Only runs that make a fetch wait are counted.
                    if (!i_if_req) begin
                        run_next = '0;
                    end else if (run_reg != RUN_MAX) begin
                        run_next = run_reg + 1'b1;
                    end
                end else if (i_if_req) begin
                    win_d_next = 1'b0;
                    addr_next  = i_if_addr;
                    we_next    = 1'b0;
                    be_next    = '1;
                    wdata_next = '0;
                    run_next   = '0;
                    state_next = ST_IF_BUSY;
                end
            end
            ST_IF_BUSY: begin
                if (i_mem_ack) begin
                    if_rdata_next = i_mem_rdata;
                    state_next    = ST_RESP;
                end
            end
            ST_D_BUSY: begin
                if (i_mem_ack) begin
                    d_rdata_next = i_mem_rdata;
                    state_next   = ST_RESP;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Memory port is driven only from latched values and only while busy.
    assign mem_phase   = (state_reg == ST_IF_BUSY) || (state_reg == ST_D_BUSY);
    assign o_mem_req   = mem_phase;
    assign o_mem_we    = mem_phase && we_reg;
    assign o_mem_be    = mem_phase ? be_reg : '0;
    assign o_mem_addr  = mem_phase ? addr_reg : '0;
    assign o_mem_wdata = mem_phase ? wdata_reg : '0;

    assign o_if_ack    = (state_reg == ST_RESP) && !win_d_reg;
    assign o_d_ack     = (state_reg == ST_RESP) && win_d_reg;
    assign o_if_rdata  = if_rdata_reg;
    assign o_d_rdata   = d_rdata_reg;
    assign o_busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: transaction-level model plus a per-cycle
// compare process, a wait-state memory responder and directed scenarios.
module tb_mem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int MAXR = 4;

    logic          i_clk  = 1'b0;
    logic          i_rstn = 1'b1;
    logic          i_if_req = 1'b0;
    logic [AW-1:0] i_if_addr = '0;
    logic [DW-1:0] o_if_rdata;
    logic          o_if_ack;
    logic          i_d_req = 1'b0;
    logic          i_d_we = 1'b0;
    logic [BW-1:0] i_d_be = '0;
    logic [AW-1:0] i_d_addr = '0;
    logic [DW-1:0] i_d_wdata = '0;
    logic [DW-1:0] o_d_rdata;
    logic          o_d_ack;
    logic          o_mem_req;
    logic          o_mem_we;
    logic [BW-1:0] o_mem_be;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_wdata;
    logic [DW-1:0] i_mem_rdata = '0;
    logic          i_mem_ack = 1'b0;
    logic          o_busy;

    always #5 i_clk = ~i_clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_RUN(MAXR)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_rdata(o_if_rdata), .o_if_ack(o_if_ack),
        .i_d_req(i_d_req), .i_d_we(i_d_we), .i_d_be(i_d_be),
        .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
        .o_d_rdata(o_d_rdata), .o_d_ack(o_d_ack),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_be(o_mem_be),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
        .o_busy(o_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return (a == 32'h100) ? 32'h0000_0013 : (a ^ 32'h5A5A_0000);
    endfunction

    // Memory responder: acks after mem_wait cycles of o_mem_req; force_ack
    // injects a stray ack regardless of the port state.
    int mem_wait  = 0;
    bit force_ack = 1'b0;
    int wcnt      = 0;
    always begin
        @(posedge i_clk);
        #2;
        if (o_mem_req) begin
            if (wcnt >= mem_wait) begin
                i_mem_ack   = 1'b1;
                i_mem_rdata = mem_fn(o_mem_addr);
            end else begin
                i_mem_ack = 1'b0;
                wcnt++;
            end
        end else begin
            i_mem_ack = force_ack;
            wcnt      = 0;
        end
    end

    // Transaction model: one transfer in flight, which is granted from the
    // request inputs, completed by a memory ack and answered one cycle later.
    bit          m_txn = 1'b0;
    bit          m_resp = 1'b0;
    bit          m_is_d = 1'b0;
    logic [AW-1:0] m_addr = '0;
    bit          m_we = 1'b0;
    logic [BW-1:0] m_be = '0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    int          m_run = 0;

    always @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            m_txn  <= 1'b0;
            m_resp <= 1'b0;
            m_run  <= 0;
        end else if (m_resp) begin
            m_txn  <= 1'b0;
            m_resp <= 1'b0;
        end else if (m_txn) begin
            if (i_mem_ack) begin
                m_resp  <= 1'b1;
                m_rdata <= i_mem_rdata;
            end
        end else if (i_d_req && !(i_if_req && m_run == MAXR)) begin
            m_txn   <= 1'b1;
            m_is_d  <= 1'b1;
            m_addr  <= i_d_addr;
            m_we    <= i_d_we;
            m_be    <= i_d_be;
            m_wdata <= i_d_wdata;
            m_run   <= i_if_req ? ((m_run < MAXR) ? m_run + 1 : MAXR) : 0;
        end else if (i_if_req) begin
            m_txn   <= 1'b1;
            m_is_d  <= 1'b0;
            m_addr  <= i_if_addr;
            m_we    <= 1'b0;
            m_be    <= '1;
            m_wdata <= '0;
            m_run   <= 0;
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    bit ack_log[$];
    int busy_cycles = 0;
    int d_ack_cnt   = 0;
    always @(negedge i_clk) begin
        if (!i_rstn) begin
            check("rst_busy", o_busy, 0);
            check("rst_mem_req", o_mem_req, 0);
            check("rst_acks", {o_if_ack, o_d_ack}, 0);
        end else begin
            check("busy", o_busy, m_txn);
            check("mem_req", o_mem_req, m_txn && !m_resp);
            check("if_ack", o_if_ack, m_resp && !m_is_d);
            check("d_ack", o_d_ack, m_resp && m_is_d);
            if (m_txn && !m_resp) begin
                busy_cycles++;
                check("mem_addr", o_mem_addr, m_addr);
                check("mem_we", o_mem_we, m_we);
                check("mem_be", o_mem_be, m_be);
                check("mem_wdata", o_mem_wdata, m_wdata);
            end
            if (m_resp && m_is_d)  check("d_rdata", o_d_rdata, m_rdata);
            if (m_resp && !m_is_d) check("if_rdata", o_if_rdata, m_rdata);
            if (o_d_ack) begin
                ack_log.push_back(1'b1);
                d_ack_cnt++;
            end
            if (o_if_ack) ack_log.push_back(1'b0);
        end
    end

    // Wait (bounded) for the requested acks, dropping each request on its ack.
    task automatic wait_acks(input bit need_if, input bit need_d, input string name);
        bit got_if;
        bit got_d;
        int cyc;
        got_if = !need_if;
        got_d  = !need_d;
        cyc    = 0;
        while (!(got_if && got_d) && cyc < 300) begin
            @(posedge i_clk);
            #1;
            cyc++;
            if (o_if_ack) begin got_if = 1'b1; i_if_req = 1'b0; end
            if (o_d_ack)  begin got_d  = 1'b1; i_d_req  = 1'b0; end
        end
        check({name, "_done"}, {got_if, got_d}, 2'b11);
        $display("txn %s: fetch_done=%0d data_done=%0d cycles=%0d", name, got_if, got_d, cyc);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    bit exp31[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    initial begin
        int n_if;
        int cyc;
        #1 i_rstn = 1'b0;
        repeat (3) step();
        check("reset_busy", o_busy, 0);
        check("reset_mem_addr", o_mem_addr, 0);
        i_rstn = 1'b1;
        step();
        check("idle_busy", o_busy, 0);

        // Fetch only, zero-wait memory.
        mem_wait  = 0;
        i_if_addr = 32'h100;
        i_if_req  = 1'b1;
        step();
        check("t1_mem_req", o_mem_req, 1);
        check("t1_mem_addr", o_mem_addr, 32'h100);
        step();
        check("t1_if_ack", o_if_ack, 1);
        check("t1_if_rdata", o_if_rdata, 32'h13);
        $display("txn fetch 0x100: ack=%0d rdata=0x%0h", o_if_ack, o_if_rdata);
        i_if_req = 1'b0;
        step();
        check("t1_idle", o_busy, 0);

        // Simultaneous fetch and load: data first.
        ack_log.delete();
        i_d_addr  = 32'h2000;
        i_d_we    = 1'b0;
        i_d_be    = 4'hF;
        i_d_req   = 1'b1;
        i_if_addr = 32'h104;
        i_if_req  = 1'b1;
        wait_acks(1'b1, 1'b1, "t2_both");
        step();
        check("t2_nacks", ack_log.size(), 2);
        if (ack_log.size() == 2) begin
            check("t2_first_is_d", ack_log[0], 1);
            check("t2_second_is_if", ack_log[1], 0);
        end

        // Continuous data with a pending fetch: D,D,D,D,IF repeating.
        ack_log.delete();
        i_d_addr  = 32'h3000;
        i_d_req   = 1'b1;
        i_if_addr = 32'h108;
        i_if_req  = 1'b1;
        n_if = 0;
        cyc  = 0;
        while (n_if < 2 && cyc < 300) begin
            step();
            cyc++;
            if (o_d_ack) i_d_addr = i_d_addr + 4;
            if (o_if_ack) begin
                n_if++;
                if (n_if < 2) i_if_addr = i_if_addr + 4;
                else begin
                    i_if_req = 1'b0;
                    i_d_req  = 1'b0;
                end
            end
        end
        check("t3_done", n_if, 2);
        step();
        check("t3_nacks", ack_log.size(), 10);
        if (ack_log.size() == 10) begin
            for (int i = 0; i < 10; i++) check($sformatf("t3_grant%0d", i), ack_log[i], exp31[i]);
        end
        $display("txn starvation run: %0d acks in %0d cycles", ack_log.size(), cyc);

        // Store with 3 wait states; request inputs disturbed while busy.
        mem_wait    = 3;
        busy_cycles = 0;
        d_ack_cnt   = 0;
        i_d_addr    = 32'h3004;
        i_d_we      = 1'b1;
        i_d_be      = 4'b0011;
        i_d_wdata   = 32'hDEAD_BEEF;
        i_d_req     = 1'b1;
        step();
        check("t4_we", o_mem_we, 1);
        i_d_addr  = 32'hFFFF_0000;
        i_d_wdata = 32'h0;
        i_d_be    = 4'hF;
        wait_acks(1'b0, 1'b1, "t4_store");
        step();
        check("t4_busy_cycles", busy_cycles, 4);
        check("t4_d_ack_count", d_ack_cnt, 1);
        i_d_we = 1'b0;

        // Stray memory ack while idle.
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        check("t5_busy", o_busy, 0);
        check("t5_acks", {o_if_ack, o_d_ack}, 0);
        step();
        check("t5_busy_after", o_busy, 0);
        check("t5_acks_after", {o_if_ack, o_d_ack}, 0);
        $display("txn stray ack: busy=%0d", o_busy);

        // Reset during a stalled load, then a normal fetch.
        mem_wait = 1000;
        i_d_addr = 32'h2400;
        i_d_req  = 1'b1;
        step();
        check("t6_mem_req", o_mem_req, 1);
        @(posedge i_clk);
        #3;
        i_rstn = 1'b0;
        #1;
        check("t6_rst_busy", o_busy, 0);
        check("t6_rst_mem", {o_mem_req, o_mem_we, o_mem_be}, 0);
        check("t6_rst_addr", o_mem_addr, 0);
        check("t6_rst_acks", {o_if_ack, o_d_ack}, 0);
        check("t6_rst_d_rdata", o_d_rdata, 0);
        check("t6_rst_if_rdata", o_if_rdata, 0);
        i_d_req   = 1'b0;
        d_ack_cnt = 0;
        repeat (2) @(posedge i_clk);
        #3;
        i_rstn = 1'b1;
        repeat (4) step();
        check("t6_no_stray_ack", d_ack_cnt, 0);
        check("t6_idle", o_busy, 0);
        mem_wait  = 0;
        i_if_addr = 32'h140;
        i_if_req  = 1'b1;
        wait_acks(1'b1, 1'b0, "t6_fetch");
        check("t6_fetch_rdata", o_if_rdata, 32'h5A5A_0140);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
